// File: rtl/codec_pkg.sv
// Shared constants and the slot bit formatter for the codec_tx I2S transmitter.
// Defining CODEC_TX_LJ_EN switches the formatter to left-justified slots.
package codec_pkg;

  localparam int CH_L       = 0;
  localparam int CH_R       = 1;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;
  localparam int POS_W      = $clog2(FRAME_BITS);
  localparam int SAMPLE_W   = 24;

  typedef enum logic [0:0] {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // Serial bit for slot position b of a sample that is `width` bits wide.
  function automatic logic slot_bit(input logic [SLOT_W-2:0] word,
                                    input logic [4:0]        width,
                                    input logic [4:0]        b);
    logic [4:0] idx;
    logic       bit_o;
    idx   = 5'd0;
    bit_o = 1'b0;
`ifdef CODEC_TX_LJ_EN
    if (b < width) begin
      idx   = width - 5'd1 - b;
      bit_o = word[idx];
    end else begin
      bit_o = 1'b0;
    end
`else
    // I2S: one idle bit after the word-select edge, then MSB first
    if ((b != 5'd0) && (b <= width)) begin
      idx   = width - b;
      bit_o = word[idx];
    end else begin
      bit_o = 1'b0;
    end
`endif
    return bit_o;
  endfunction

endpackage

// File: rtl/codec_tx_if.sv
// Sample input and serial codec output bundle of codec_tx.
// master = filter side, slave = the transmitter itself.
interface codec_tx_if #(
  parameter int DATA_W = codec_pkg::SAMPLE_W
) ();

  logic [1:0]        din_valid;
  logic [DATA_W-1:0] din;
  logic              bclk;
  logic              lrclk;
  logic              sdata;
  logic              underrun;
  logic              overrun;

  modport master (
    output din_valid, din,
    input  bclk, lrclk, sdata, underrun, overrun
  );

  modport slave (
    input  din_valid, din,
    output bclk, lrclk, sdata, underrun, overrun
  );

endinterface

// File: rtl/codec_clkgen.sv
// BCLK divider and frame position counter for codec_tx.
// fall and bit_cnt_nxt announce, one cycle early, the edge on which bclk drops.
module codec_clkgen
  import codec_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             bclk,
  output logic             lrclk,
  output logic             fall,
  output logic [POS_W-1:0] bit_cnt_nxt
);

  localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [POS_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             lrclk_q, lrclk_d;
  logic             term_s;
  logic             fall_s;

  // Divider, bclk toggle and frame position on each fall event
  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    term_s    = (div_cnt_q == CNT_LAST);
    fall_s    = term_s & bclk_q;
    if (term_s) begin
      div_cnt_d = {CNT_W{1'b0}};
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
      bclk_d    = bclk_q;
    end
    if (fall_s) begin
      bit_cnt_d = bit_cnt_q + POS_W'(1);
      lrclk_d   = bit_cnt_d[POS_W-1];
    end else begin
      bit_cnt_d = bit_cnt_q;
      lrclk_d   = lrclk_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= {CNT_W{1'b0}};
      bclk_q    <= 1'b0;
      bit_cnt_q <= POS_W'(FRAME_BITS - 1);
      lrclk_q   <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign fall        = fall_s;
  assign bit_cnt_nxt = bit_cnt_d;

endmodule

// File: rtl/codec_tx.sv
// I2S stereo transmitter: per-channel holding registers, frame load, serializer
// and overrun/underrun flags. Define CODEC_TX_LJ_EN for left-justified slots.
module codec_tx
  import codec_pkg::*;
#(
  parameter int BCLK_DIV = 16,
  parameter int DATA_W   = SAMPLE_W
) (
  input  logic       clk,
  input  logic       rst,
  codec_tx_if.slave  bus
);

  logic             fall_s;
  logic [POS_W-1:0] bit_cnt_nxt_s;
  logic             bclk_s;
  logic             lrclk_s;
  logic             load_s;
  logic [1:0]       pend_base_s;
  logic [DATA_W-1:0] slot_word_s;

  logic [DATA_W-1:0] hold_q  [2];
  logic [DATA_W-1:0] hold_d  [2];
  logic [DATA_W-1:0] shift_q [2];
  logic [DATA_W-1:0] shift_d [2];
  logic [1:0]        pend_q, pend_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;
  logic              overrun_q, overrun_d;

  codec_clkgen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .bclk        (bclk_s),
    .lrclk       (lrclk_s),
    .fall        (fall_s),
    .bit_cnt_nxt (bit_cnt_nxt_s)
  );

  // Capture, frame load and serial bit selection
  always_comb begin
    hold_d      = hold_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_base_s = pend_q;
    underrun_d  = 1'b0;
    overrun_d   = 1'b0;
    sdata_d     = sdata_q;
    slot_word_s = {DATA_W{1'b0}};
    load_s      = fall_s && (bit_cnt_nxt_s == {POS_W{1'b0}});

    // The load consumes the pre-write hold values; a same-cycle write re-arms pend
    if (load_s) begin
      shift_d[CH_L] = hold_q[CH_L];
      shift_d[CH_R] = hold_q[CH_R];
      pend_base_s   = 2'b00;
      underrun_d    = (pend_q != 2'b11);
    end else begin
      shift_d     = shift_q;
      pend_base_s = pend_q;
      underrun_d  = 1'b0;
    end

    for (int ch = 0; ch < 2; ch++) begin
      if (bus.din_valid[ch]) begin
        hold_d[ch] = bus.din;
      end else begin
        hold_d[ch] = hold_q[ch];
      end
    end
    pend_d    = pend_base_s | bus.din_valid;
    overrun_d = |(pend_base_s & bus.din_valid);

    if (fall_s) begin
      case (slot_e'(bit_cnt_nxt_s[POS_W-1]))
        SLOT_LEFT:  slot_word_s = shift_d[CH_L];
        SLOT_RIGHT: slot_word_s = shift_d[CH_R];
        default:    slot_word_s = {DATA_W{1'b0}};
      endcase
      sdata_d = slot_bit(31'(slot_word_s), 5'(DATA_W), bit_cnt_nxt_s[4:0]);
    end else begin
      slot_word_s = {DATA_W{1'b0}};
      sdata_d     = sdata_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q[CH_L]  <= {DATA_W{1'b0}};
      hold_q[CH_R]  <= {DATA_W{1'b0}};
      shift_q[CH_L] <= {DATA_W{1'b0}};
      shift_q[CH_R] <= {DATA_W{1'b0}};
      pend_q        <= 2'b00;
      sdata_q       <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.bclk     = bclk_s;
  assign bus.lrclk    = lrclk_s;
  assign bus.sdata    = sdata_q;
  assign bus.underrun = underrun_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: doc/codec_tx.md
Name: codec_tx

Overview:
- I2S transmitter at the output end of the FIR audio path.
- Accepts per-channel 24-bit samples from the filter (valid strobes with one shared data bus) and holds them in per-channel registers.
- Serializes them to the codec DAC as a 64-BCLK stereo frame with 32-bit slots.
- Generates BCLK and LRCLK from the system clock and flags overrun and underrun.

Parameters:
- BCLK_DIV, 16, system clocks per BCLK half-period (≥1); frame rate = f_clk / (128·BCLK_DIV).
- DATA_W, 24, sample width in bits, s.23 format (≤31).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- din_valid  in  2  bit0 = left sample valid, bit1 = right sample valid; single-cycle strobes
- din  in  DATA_W  sample, two's complement, written to the channel(s) strobed
- bclk  out  1  serial bit clock to codec
- lrclk  out  1  word select: 0 = left slot, 1 = right slot
- sdata  out  1  serial data, changes on BCLK falling edge
- underrun  out  1  one-cycle pulse: a frame started with a stale channel
- overrun  out  1  one-cycle pulse: channel rewritten before its previous sample was sent

Behaviour:
- Reset values:
  - bclk = 0, lrclk = 1, sdata = 0, underrun = 0, overrun = 0.
  - Holding and shift registers = 0, pending flags = 0.
  - Divider count = 0, bit_cnt = 63.
- Divider:
  - Counter runs 0..BCLK_DIV-1; at terminal count bclk toggles.
  - A 1→0 toggle is a "fall event".
- Frame position:
  - 6-bit bit_cnt increments (wraps 63→0) on each fall event.
  - lrclk is registered equal to bit_cnt[5] after the increment.
  - Slot bit b = bit_cnt[4:0].
- Sample capture:
  - din_valid[i] writes din into hold[i] and sets pend[i].
  - 2'b11 writes both channels.
  - If pend[i] is already set, raise overrun for one cycle; the new value overwrites the old.
- Frame load: on the fall event that moves bit_cnt to 0:
  - Copy hold[0] and hold[1] into shift regs L and R; clear both pend flags.
  - If either pend was 0 before the load, raise underrun for one cycle; the stale (previous) value is sent.
  - If din_valid arrives in the same cycle as the load: the load uses the pre-write hold value; the new write lands in hold and sets pend after the clear (pend ends at 1).
- Serial data (standard I2S, one-bit delay), driven on the fall event for slot bit b:
  - b = 0 → 0.
  - b = 1..DATA_W → bit (DATA_W−b) of L (left slot) or R (right slot); MSB first.
  - b > DATA_W → 0.
- Latency: a sample written before a frame load appears starting at that frame. From the load, the left MSB appears 2·BCLK_DIV clocks later, on the next fall event.
- Rst mid-frame: all state returns to reset values immediately; the frame in flight is abandoned. The first fall event after reset loads a new frame (bit_cnt 63→0).
- lrclk toggles only on fall events; bclk duty is 50%.

Optional Feature:
- Macro: CODEC_TX_LJ_EN.
- Defined: left-justified format.
  - b = 0..DATA_W−1 → bit (DATA_W−1−b); other bits 0.
  - lrclk polarity is unchanged.
- Undefined: I2S one-bit-delay format as specified above.

Decomposition:
- Shared package codec_pkg holds:
  - CH_L = 0 and CH_R = 1
  - SLOT_W = 32 and FRAME_BITS = 64
  - Sample width constant 24
- Sub-module codec_clkgen holds the divider, bclk, fall-event strobe and bit_cnt/lrclk.
- codec_tx keeps capture, pend/flag logic and shift registers.

Test Plan:
- BCLK_DIV = 2: after rst release, bclk period is 4 clocks; the first lrclk 1→0 coincides with the first bclk fall; lrclk has a 64-bclk period.
- Left 24'hA5A5A5 and right 24'h800001 written before the frame load → left slot bits 1..24 = A5A5A5 MSB first, bits 0 and 25..31 = 0; right slot carries 800001; no underrun pulse.
- Only left written before a load (right last written 24'h123456) → underrun pulses once at the load; right slot repeats 123456.
- Left written twice (24'h000001 then 24'h7FFFFF) before a load → one overrun pulse; left slot carries 7FFFFF.
- din_valid = 2'b10 in exactly the load cycle → the current frame sends the old right value; the next frame sends the new value with no underrun.
- rst asserted mid-right-slot → next cycle bclk = 0, lrclk = 1, sdata = 0; after release the frame restarts cleanly.
- With CODEC_TX_LJ_EN defined, left 24'hC00000 → slot bits 0,1 = 1 and bits 2..31 = 0.
